// File: rtl/sw_debounce_pkg.sv
// Shared defaults and sizing helpers for the slide-switch debouncer.
package sw_debounce_pkg;

    localparam int SW_WIDTH        = 10;
    localparam int SW_TICK_DIV     = 50000;
    localparam int SW_STABLE_TICKS = 10;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One debounced switch bit: stability counter, accepted level and registered edge pulses.
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = SW_STABLE_TICKS
) (
    input  logic clk,
    input  logic reset,
    input  logic s,
    input  logic tick,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = cnt_width(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
                level_d = s;
                cnt_d   = '0;
                rise_d  = s;
                fall_d  = ~s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// Switch conditioning: two-flop synchronisers, shared sample tick, per-bit debounce.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH        = SW_WIDTH,
    parameter int TICK_DIV     = SW_TICK_DIV,
    parameter int STABLE_TICKS = SW_STABLE_TICKS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sample_tick
);

    localparam int TICK_W = cnt_width(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [WIDTH-1:0]  sync1_q, sync1_d;
    logic [WIDTH-1:0]  sync2_q, sync2_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;

    always_comb begin
        sync1_d    = sw_raw;
        sync2_d    = sync1_q;
        tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TICK_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            tick_cnt_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // With TICK_DIV=1 the counter is stuck at 0 and the tick is permanently high.
    assign sample_tick = (tick_cnt_q == TICK_LAST);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_bit (
            .clk  (clk),
            .reset(reset),
            .s    (sync2_q[i]),
            .tick (sample_tick),
            .level(sw_out[i]),
            .rise (sw_rise[i]),
            .fall (sw_fall[i])
        );
    end

endmodule
